// File: rtl/tdm_demux14.sv
// tdm_demux14 : 1-to-4 time-division demultiplexer.
//
// Collects a serial stream of samples (slot order 0,1,2,3, slot 0 marked by
// sof) and presents each complete frame on y0..y3 together, with a
// one-cycle frame_valid pulse. Slots 0..2 are held in shadow registers so
// that y0..y3 only change when a whole frame has arrived.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         incoming multiplexed sample (WIDTH bits)
//   din_valid   din carries a sample this cycle
//   sof         start of frame, marks din as slot 0 (ignored without din_valid)
//   y0..y3      channels of the last complete frame
//   frame_valid one-cycle pulse, y0..y3 updated this cycle
//   slot        next expected slot index (0 while hunting)
//   sync_err    one-cycle pulse, a partial frame was aborted by an early sof
module tdm_demux14 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             sync_err
);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // Pulse outputs are cleared every cycle unless re-asserted below.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        unique case (state)
          HUNT: begin
            // Samples without sof are dropped silently until alignment.
            if (sof) begin
              s0    <= din;
              slot  <= 2'd1;
              state <= COLLECT;
            end
          end
          COLLECT: begin
            if (sof) begin
              // Early sof: abandon the partial frame and restart at slot 0.
              sync_err <= 1'b1;
              s0       <= din;
              slot     <= 2'd1;
            end else begin
              unique case (slot)
                2'd1: begin
                  s1   <= din;
                  slot <= 2'd2;
                end
                2'd2: begin
                  s2   <= din;
                  slot <= 2'd3;
                end
                2'd3: begin
                  // Last slot goes straight to y3, bypassing the shadows.
                  y0          <= s0;
                  y1          <= s1;
                  y2          <= s2;
                  y3          <= din;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
                  state       <= HUNT;
                end
                default: begin
                  // Slot 0 never occurs mid-frame; realign defensively.
                  slot  <= 2'd0;
                  state <= HUNT;
                end
              endcase
            end
          end
          default: begin
            slot  <= 2'd0;
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux14.sv
// tb_tdm_demux14 : randomized, scoreboard-checked bench for tdm_demux14.
//
// The driver applies one input vector per cycle on the falling edge and runs
// a frame-level reference model (a queue of samples of the frame under
// construction). It pushes a per-cycle expectation and, for every completed
// frame, the expected channel values. A separate monitor samples just after
// each rising edge and pops/compares.
module tb_tdm_demux14;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         sync_err;

  tdm_demux14 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .frame_valid(frame_valid),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  typedef struct {
    logic        fv;
    logic        se;
    logic [1:0]  slot;
    logic [15:0] y;
  } exp_t;

  exp_t         cycleQ[$];
  logic [15:0]  frameQ[$];
  logic [W-1:0] partial[$];
  logic [W-1:0] lastY[4];

  int nVectors = 0;
  int nChecks  = 0;
  int nFail    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of input and advance the reference model.
  task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    din_valid = v;
    sof       = s;
    din       = d;
    nVectors++;
    e.fv = 1'b0;
    e.se = 1'b0;
    if (v) begin
      if (s) begin
        e.se = (partial.size() != 0);
        partial.delete();
        partial.push_back(d);
      end else if (partial.size() != 0) begin
        partial.push_back(d);
        if (partial.size() == 4) begin
          for (int i = 0; i < 4; i++) lastY[i] = partial[i];
          e.fv = 1'b1;
          frameQ.push_back({lastY[0], lastY[1], lastY[2], lastY[3]});
          partial.delete();
        end
      end
    end
    e.slot = 2'(partial.size());
    e.y    = {lastY[0], lastY[1], lastY[2], lastY[3]};
    cycleQ.push_back(e);
  endtask

  task automatic sendFrame(input logic [15:0] f, input int gap);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i == 0, f[15-4*i -: 4]);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 4'h0);
    end
  endtask

  task automatic modelReset();
    partial.delete();
    for (int i = 0; i < 4; i++) lastY[i] = '0;
  endtask

  // Monitor: samples after each rising edge, independent of the driver.
  initial begin
    exp_t e;
    logic [15:0] f;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && cycleQ.size() > 0) begin
        e = cycleQ.pop_front();
        checkOutput("frame_valid", 16'(frame_valid), 16'(e.fv));
        checkOutput("sync_err", 16'(sync_err), 16'(e.se));
        checkOutput("slot", 16'(slot), 16'(e.slot));
        checkOutput("y_hold", {y0, y1, y2, y3}, e.y);
        if (frame_valid) begin
          if (frameQ.size() == 0) begin
            checkOutput("unexpected_frame", 16'd1, 16'd0);
          end else begin
            f = frameQ.pop_front();
            checkOutput("frame_y", {y0, y1, y2, y3}, f);
          end
        end
      end
    end
  end

  initial begin
    logic v;
    logic s;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    modelReset();
    #3;
    checkOutput("reset_y", {y0, y1, y2, y3}, 16'h0000);
    checkOutput("reset_slot", 16'(slot), 16'd0);
    checkOutput("reset_pulses", {14'd0, frame_valid, sync_err}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, then back-to-back frame.
    sendFrame(16'hA5C3, 0);
    sendFrame(16'h1234, 0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    // Gaps of two idle cycles between samples.
    sendFrame(16'h6789, 2);
    // Early sof aborts a partial frame.
    applyStimulus(1'b1, 1'b1, 4'h1);
    applyStimulus(1'b1, 1'b0, 4'h2);
    sendFrame(16'hFEDC, 0);
    // Samples without sof while hunting are discarded.
    applyStimulus(1'b1, 1'b0, 4'h9);
    applyStimulus(1'b1, 1'b0, 4'h9);
    sendFrame(16'h1234, 0);

    // Asynchronous reset between edges after the slot-2 sample.
    applyStimulus(1'b1, 1'b1, 4'h7);
    applyStimulus(1'b1, 1'b0, 4'h8);
    applyStimulus(1'b1, 1'b0, 4'h9);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sof       = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_y", {y0, y1, y2, y3}, 16'h0000);
    checkOutput("async_rst_slot", 16'(slot), 16'd0);
    checkOutput("async_rst_fv", 16'(frame_valid), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0);
    sendFrame(16'hB0D4, 1);

    // Randomized traffic with gaps, stray samples and early sofs.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (!v)
        s = 1'($urandom_range(0, 1));
      else if (partial.size() == 0)
        s = ($urandom_range(0, 3) != 0);
      else
        s = ($urandom_range(0, 9) == 0);
      applyStimulus(v, s, 4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, 1'b0, 4'h0);

    for (int i = 0; i < 10 && cycleQ.size() > 0; i++) @(posedge clk);
    #3;
    checkOutput("cycleQ_drain", 16'(cycleQ.size()), 16'd0);
    checkOutput("frameQ_drain", 16'(frameQ.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule

// File: doc/tdm_demux14.md
Name: tdm_demux14

Overview:
- Receive-side counterpart of the 4:1 mux: a 1-to-4 time-division demultiplexer.
- Accepts a serial stream of samples in slot order 0,1,2,3, each frame marked by a start-of-frame flag. It steers each sample into its channel slot.
- Presents all four channels together, double-buffered, with a one-cycle frame_valid pulse.
- Sits at the far end of a link driven by a slot-cycling 4:1 mux. Recovers i0..i3 as y0..y3.

Parameters:
WIDTH, 1, bit width of each sample and of each channel output.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  incoming multiplexed sample
din_valid  input  1  din carries a sample this cycle
sof  input  1  start of frame; qualifies din as slot 0; ignored when din_valid=0
y0  output  WIDTH  channel 0 of last complete frame
y1  output  WIDTH  channel 1 of last complete frame
y2  output  WIDTH  channel 2 of last complete frame
y3  output  WIDTH  channel 3 of last complete frame
frame_valid  output  1  one-cycle pulse: y0..y3 updated this cycle
slot  output  2  next expected slot index (0..3)
sync_err  output  1  one-cycle pulse: frame aborted by early sof

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y0..y3 = 0; frame_valid = 0; sync_err = 0; slot = 0.
  - Shadow registers s0..s2 = 0. State = HUNT.
  - Release takes effect on the first clk edge with rst_n=1.
- States: HUNT (waiting for sof) and COLLECT (mid-frame).
- An accepted sample is a rising edge with din_valid=1. Cycles with din_valid=0 change nothing except clearing the pulse outputs.
- HUNT:
  - din_valid=1, sof=1: s0 <= din; slot <= 1; go to COLLECT.
  - din_valid=1, sof=0: sample discarded; no error; stay in HUNT; slot stays 0.
- COLLECT, din_valid=1, sof=0:
  - slot=1 or 2: s[slot] <= din; slot increments.
  - slot=3: y0<=s0, y1<=s1, y2<=s2, y3<=din, all on the same edge. frame_valid <= 1; slot <= 0; go to HUNT.
- COLLECT, din_valid=1, sof=1 (early sof, frame incomplete):
  - sync_err <= 1; partial frame dropped; y0..y3 unchanged.
  - The sample is treated as slot 0 of a new frame: s0 <= din; slot <= 1; stay in COLLECT.
- Latency: y0..y3 and frame_valid change on the same edge that accepts the slot-3 sample. They are visible the cycle after slot 3 is presented.
- frame_valid and sync_err are single-cycle pulses. They deassert on the next edge regardless of input.
- y0..y3 hold their values between frames; no output glitches while a frame is being collected.
- Back-to-back frames: the cycle after slot 3 may carry sof+din_valid. It is accepted immediately in HUNT, with no dead cycle. Sustained throughput is one frame per 4 valid cycles.
- Gaps: din_valid may drop at any point mid-frame. slot and shadow registers hold; there is no timeout.
- Reset mid-frame: partial frame lost; outputs return to 0 immediately, without waiting for a clock.
- slot output: reflects the internal counter directly (registered). It is 0 in HUNT.
- Width: samples are stored verbatim; no arithmetic. The slot counter wraps 3 to 0 only via frame completion.

Test Plan:
- Reset then basic frame (WIDTH=4): din 0xA(sof), 0x5, 0xC, 0x3 on consecutive valid cycles -> cycle after 4th sample: y0..y3 = A,5,C,3; frame_valid high exactly 1 cycle; sync_err stays 0.
- Back-to-back: frame A,5,C,3 immediately followed by 1(sof),2,3,4 -> two frame_valid pulses 4 cycles apart; final y0..y3 = 1,2,3,4; y holds A,5,C,3 during the second frame's collection.
- Gaps: frame 6(sof),7,8,9 with din_valid low 2 cycles between each sample -> identical result y = 6,7,8,9; slot reads 1,2,3 while stalled.
- Early sof: 1(sof), 2, then F(sof), E, D, C -> sync_err pulse on the edge accepting F; y unchanged by the partial frame; then y = F,E,D,C with one frame_valid.
- Hunt discard: samples 9,9 without sof after reset, then 1(sof),2,3,4 -> no frame_valid or sync_err from the discarded samples; y = 1,2,3,4.
- Async reset mid-frame: drop rst_n between clk edges after slot 2 -> y0..y3 = 0, slot = 0, frame_valid = 0 immediately. After release, a full frame decodes normally.
